// File: rtl/counter_scheduler_pkg.sv
// counter_scheduler_pkg: FSM state encodings and a one-hot helper for the shared timer.
// No ports. It provides S_IDLE/S_COUNT/S_DONE, MAX_REQ and onehot(idx).
package counter_scheduler_pkg;

    localparam int MAX_REQ = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// counter_scheduler_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
// Ports: req (requests), ptr (highest-priority index), enable (0 forces no grant),
//        grant_next (one-hot winner, 0 if none), index (binary winner).
module counter_scheduler_rr_arbiter
    import counter_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant_next,
    output logic [PW-1:0]    index
);

    logic found;

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (enable && !found && req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                index = PW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign grant_next = found ? N_REQ'(onehot(3'(index))) : '0;

endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: one shared down-counter timer, granted round-robin, with a done pulse to the owner.
// Ports: clk, reset (sync, active-high), req (held until done, else abort),
//        duration (WIDTH bits per requester, sampled at grant), grant (one-hot owner),
//        done (one-cycle completion pulse), busy (any grant active), count_out (remaining count).
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] duration,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       count_out
);

    localparam int PW = $clog2(N_REQ);

    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [PW-1:0]    own;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    idx;
    logic [PW-1:0]    nxt;
    logic [N_REQ-1:0] win;
    logic [WIDTH-1:0] dur_w;

    counter_scheduler_rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req        (req),
        .ptr        (ptr),
        .enable     (state == S_IDLE),
        .grant_next (win),
        .index      (idx)
    );

    assign dur_w = duration[int'(idx)*WIDTH +: WIDTH];
    assign nxt   = (own == PW'(N_REQ-1)) ? '0 : own + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            own   <= '0;
            ptr   <= '0;
        end else if (state == S_IDLE) begin
            if (|win) begin
                own   <= idx;
                cnt   <= dur_w;
                state <= (dur_w != '0) ? S_COUNT : S_DONE;
            end
        end else if (!req[own] || state != S_COUNT) begin
            // Abort and normal completion both release the timer and rotate priority
            state <= S_IDLE;
            cnt   <= '0;
            ptr   <= nxt;
        end else begin
            cnt <= cnt - 1'b1;
            if (cnt == WIDTH'(1)) state <= S_DONE;
        end
    end

    assign busy      = state != S_IDLE;
    assign grant     = busy ? N_REQ'(onehot(3'(own))) : '0;
    assign done      = (state == S_DONE) ? N_REQ'(onehot(3'(own))) : '0;
    assign count_out = cnt;

endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed table plus hand-written sequences for counter_scheduler (N_REQ=4, WIDTH=4).
module tb_counter_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] duration = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count_out;

    int n_cmp = 0;
    int n_bad = 0;

    counter_scheduler #(.N_REQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .duration  (duration),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [15:0] dur;
        logic [3:0]  g;
        logic [3:0]  dn;
        logic        b;
        logic [3:0]  c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [15:0] dur,
                                input logic [3:0] g, input logic [3:0] dn, input logic b,
                                input logic [3:0] c);
        vec_t v;
        v.rst = rst; v.rq = rq; v.dur = dur; v.g = g; v.dn = dn; v.b = b; v.c = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] d);
        reset = r;
        req = rq;
        duration = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] g, input logic [3:0] dn,
                              input logic b, input logic [3:0] c);
        chk({nm, " grant"}, 32'(grant), 32'(g));
        chk({nm, " done"}, 32'(done), 32'(dn));
        chk({nm, " busy"}, 32'(busy), 32'(b));
        chk({nm, " count"}, 32'(count_out), 32'(c));
        chk({nm, " done_vs_grant"}, 32'(done & ~grant), 32'(0));
    endtask

    initial begin
        // single request, D=5: 5 COUNT cycles then DONE, then idle
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 4'd5));
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 4'd4));
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 4'd3));
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 4'd2));
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 1, 4'd1));
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0001, 1, 4'd0));
        tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0000, 4'b0000, 0, 4'd0));
        tbl.push_back(mk(0, 4'b0000, 16'h0005, 4'b0000, 4'b0000, 0, 4'd0));
        // zero duration on requester 2: straight to DONE
        tbl.push_back(mk(0, 4'b0100, 16'h0000, 4'b0100, 4'b0100, 1, 4'd0));
        tbl.push_back(mk(0, 4'b0100, 16'h0000, 4'b0000, 4'b0000, 0, 4'd0));
        tbl.push_back(mk(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 4'd0));
        // round robin from a fresh reset, all D=2
        tbl.push_back(mk(1, 4'b1111, 16'h2222, 4'b0000, 4'b0000, 0, 4'd0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 4'b1111, 16'h2222, 4'(1 << k), 4'b0000, 1, 4'd2));
            tbl.push_back(mk(0, 4'b1111, 16'h2222, 4'(1 << k), 4'b0000, 1, 4'd1));
            tbl.push_back(mk(0, 4'b1111, 16'h2222, 4'(1 << k), 4'(1 << k), 1, 4'd0));
            tbl.push_back(mk(0, 4'b1111, 16'h2222, 4'b0000, 4'b0000, 0, 4'd0));
        end
        tbl.push_back(mk(0, 4'b1111, 16'h2222, 4'b0001, 4'b0000, 1, 4'd2));
        tbl.push_back(mk(0, 4'b0000, 16'h2222, 4'b0000, 4'b0000, 0, 4'd0));

        step(1, 4'b0000, 16'h0000);
        expect_out("reset", 4'b0000, 4'b0000, 0, 4'd0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rq, tbl[i].dur);
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].dn, tbl[i].b, tbl[i].c);
        end

        // reset mid-count (ptr is 1 here); afterwards requester 0 must have priority again
        step(0, 4'b0001, 16'h000A);
        expect_out("rst_mid load", 4'b0001, 4'b0000, 1, 4'd10);
        for (int c = 9; c >= 6; c--) begin
            step(0, 4'b0001, 16'h000A);
            expect_out($sformatf("rst_mid c%0d", c), 4'b0001, 4'b0000, 1, 4'(c));
        end
        step(1, 4'b0001, 16'h000A);
        expect_out("rst_mid reset", 4'b0000, 4'b0000, 0, 4'd0);
        step(0, 4'b0011, 16'h0033);
        expect_out("rst_mid ptr0", 4'b0001, 4'b0000, 1, 4'd3);
        step(0, 4'b0000, 16'h0033);
        expect_out("rst_mid drop", 4'b0000, 4'b0000, 0, 4'd0);

        // abort: requester 2 drops at count 4; ptr moves to 3, beating pending requester 0
        step(1, 4'b0000, 16'h1800);
        step(0, 4'b0100, 16'h1800);
        expect_out("abort load", 4'b0100, 4'b0000, 1, 4'd8);
        for (int c = 7; c >= 4; c--) begin
            step(0, 4'b0100, 16'h1800);
            expect_out($sformatf("abort c%0d", c), 4'b0100, 4'b0000, 1, 4'(c));
        end
        step(0, 4'b1001, 16'h1800);
        expect_out("abort edge", 4'b0000, 4'b0000, 0, 4'd0);
        step(0, 4'b1001, 16'h1800);
        expect_out("abort next", 4'b1000, 4'b0000, 1, 4'd1);
        step(0, 4'b1001, 16'h1800);
        expect_out("abort next done", 4'b1000, 4'b1000, 1, 4'd0);
        step(0, 4'b0000, 16'h1800);
        expect_out("abort idle", 4'b0000, 4'b0000, 0, 4'd0);

        // max duration 15: counts 15..1 in COUNT, done on the 16th cycle, no wrap
        step(1, 4'b0000, 16'h000F);
        step(0, 4'b0001, 16'h000F);
        expect_out("max load", 4'b0001, 4'b0000, 1, 4'd15);
        for (int c = 14; c >= 1; c--) begin
            step(0, 4'b0001, 16'h000F);
            expect_out($sformatf("max c%0d", c), 4'b0001, 4'b0000, 1, 4'(c));
        end
        step(0, 4'b0001, 16'h000F);
        expect_out("max done", 4'b0001, 4'b0001, 1, 4'd0);
        step(0, 4'b0000, 16'h000F);
        expect_out("max idle", 4'b0000, 4'b0000, 0, 4'd0);
        step(0, 4'b0000, 16'h000F);
        expect_out("max stay", 4'b0000, 4'b0000, 0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
